// File: rtl/membus_pkg.sv
// Shared constants, state encoding and field helper
// for the parametrised KA10 membus core memory.
package membus_pkg;

  localparam int WORD_W  = 36;
  localparam int SEL_W   = 4;
  localparam int VEC_MAX = 512;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACK   = 3'd1;
  localparam logic [2:0] RD    = 3'd2;
  localparam logic [2:0] WWAIT = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] REC   = 3'd5;

  // Field p of width w from a packed vector.
  function automatic logic [63:0] field(
    input logic [VEC_MAX-1:0] v,
    input int                 p,
    input int                 w
  );
    logic [VEC_MAX-1:0] s;
    s = v >> (p * w);
    return s[63:0] & ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/membus_arb.sv
// Port arbiter: fixed priority or round-robin,
// pointer holds the first port searched next time.
module membus_arb
  import membus_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int ARB_RR = 0,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              adv,
  input  logic [NPORTS-1:0] elig,
  output logic [NPORTS-1:0] gnt,
  output logic [IDX_W-1:0]  gidx,
  output logic              gnt_vld
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  int               j;

  // Search the eligible vector from the start point.
  always_comb begin
    gnt     = '0;
    gidx    = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int i = 0; i < NPORTS; i++) begin
      j = (ARB_RR != 0) ? (int'(ptr_q) + i) % NPORTS : i;
      if (!gnt_vld && elig[j]) begin
        gnt_vld = 1'b1;
        gidx    = IDX_W'(j);
      end
    end
    if (gnt_vld) gnt = NPORTS'(1) << gidx;
  end

  // Move the start point past the port just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (clr)
      ptr_d = '0;
    else if (adv && gnt_vld)
      ptr_d = IDX_W'((int'(gidx) + 1) % NPORTS);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
  end

endmodule

// File: rtl/membus_core_n.sv
// N-port KA10 membus core memory with read, write,
// read-pause-write and write-restore timeout.
module membus_core_n
  import membus_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int ADDR_W = 15,
  parameter logic [SEL_W*NPORTS-1:0] MEMSEL = '0,
  parameter int ARB_RR  = 0,
  parameter int RD_DLY  = 3,
  parameter int REC_DLY = 2,
  parameter int WR_TMO  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     power,
  input  logic [NPORTS-1:0]        membus_rq_cyc,
  input  logic [NPORTS-1:0]        membus_rd_rq,
  input  logic [NPORTS-1:0]        membus_wr_rq,
  input  logic [NPORTS-1:0]        membus_wr_rs,
  input  logic [NPORTS-1:0]        membus_fmc_select,
  input  logic [SEL_W*NPORTS-1:0]  membus_sel,
  input  logic [ADDR_W*NPORTS-1:0] membus_ma,
  input  logic [WORD_W-1:0]        membus_mb_in,
  output logic [NPORTS-1:0]        membus_addr_ack,
  output logic [NPORTS-1:0]        membus_rd_rs,
  output logic [WORD_W-1:0]        membus_mb_out,
  output logic                     busy
);

  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CNT_W = 16;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [NPORTS-1:0] gsel_q, gsel_d;
  logic [ADDR_W-1:0] ma_q, ma_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wd;

  logic [NPORTS-1:0] elig;
  logic [NPORTS-1:0] gnt;
  logic [IDX_W-1:0]  gidx;
  logic              gnt_vld;
  logic              halt;
  logic              rd_last;
  logic              wrs_g;

  assign halt    = !reset || !power;
  assign rd_last = (state_q == RD)
                && (cnt_q == CNT_W'(RD_DLY - 1));
  assign wrs_g   = membus_wr_rs[gidx_q];

  // Decide which ports are currently asking for this memory.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NPORTS; p++) begin
      elig[p] = membus_rq_cyc[p]
              & (membus_rd_rq[p] | membus_wr_rq[p])
              & ~membus_fmc_select[p]
              & (field(VEC_MAX'(membus_sel), p, SEL_W)
                 == field(VEC_MAX'(MEMSEL), p, SEL_W));
    end
  end

  membus_arb #(
    .NPORTS (NPORTS),
    .ARB_RR (ARB_RR),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk     (clk),
    .clr     (halt),
    .adv     (state_q == IDLE),
    .elig    (elig),
    .gnt     (gnt),
    .gidx    (gidx),
    .gnt_vld (gnt_vld)
  );

  // Memory cycle sequencing and write-back selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gidx_d  = gidx_q;
    gsel_d  = gsel_q;
    ma_d    = ma_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    mem_wd  = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = ACK;
          cnt_d   = '0;
          gidx_d  = gidx;
          gsel_d  = gnt;
          ma_d    = ADDR_W'(field(VEC_MAX'(membus_ma),
                                  int'(gidx), ADDR_W));
          rd_d    = membus_rd_rq[gidx];
          wr_d    = membus_wr_rq[gidx];
        end
      end
      ACK: begin
        state_d = rd_q ? RD : WWAIT;
        cnt_d   = '0;
      end
      RD: begin
        if (rd_last) begin
          state_d = wr_q ? WWAIT : REC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WWAIT: begin
        if (wrs_g) begin
          wdata_d = membus_mb_in;
          state_d = WRITE;
        end else if (cnt_q == CNT_W'(WR_TMO - 1)) begin
          mem_we  = 1'b1;
          mem_wd  = rd_q ? mem_rdata : '0;
          state_d = REC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        mem_we  = 1'b1;
        mem_wd  = wdata_q;
        state_d = REC;
        cnt_d   = '0;
      end
      REC: begin
        if (cnt_q == CNT_W'(REC_DLY - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (halt) begin
      state_d = IDLE;
      cnt_d   = '0;
      mem_we  = 1'b0;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    gidx_q  <= gidx_d;
    gsel_q  <= gsel_d;
    ma_q    <= ma_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  // Core array with registered read of the latched address.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ma_q] <= mem_wd;
    mem_rdata <= mem[ma_q];
  end

  // Bus strobes and read data.
  always_comb begin
    membus_addr_ack = (state_q == ACK) ? gsel_q : '0;
    membus_rd_rs    = rd_last ? gsel_q : '0;
    membus_mb_out   = rd_last ? mem_rdata : '0;
    busy            = (state_q != IDLE);
  end

endmodule

// File: tb/tb_membus_core_n.sv
// Directed bench for membus_core_n: a fixed-priority
// and a round-robin instance share one stimulus bus.
module tb_membus_core_n;

  localparam int NP = 4;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          power;
  logic [NP-1:0] rq_cyc, rd_rq, wr_rq, wr_rs, fmc;
  logic [4*NP-1:0]  sel;
  logic [AW*NP-1:0] ma;
  logic [35:0]      mb_in;

  logic [NP-1:0] addr_ack, rd_rs;
  logic [35:0]   mb_out;
  logic          busy;
  logic [NP-1:0] addr_ack_rr, rd_rs_rr;
  logic [35:0]   mb_out_rr;
  logic          busy_rr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  membus_core_n #(.ARB_RR(0)) dut (
    .clk               (clk),
    .reset             (reset),
    .power             (power),
    .membus_rq_cyc     (rq_cyc),
    .membus_rd_rq      (rd_rq),
    .membus_wr_rq      (wr_rq),
    .membus_wr_rs      (wr_rs),
    .membus_fmc_select (fmc),
    .membus_sel        (sel),
    .membus_ma         (ma),
    .membus_mb_in      (mb_in),
    .membus_addr_ack   (addr_ack),
    .membus_rd_rs      (rd_rs),
    .membus_mb_out     (mb_out),
    .busy              (busy)
  );

  membus_core_n #(.ARB_RR(1)) dut_rr (
    .clk               (clk),
    .reset             (reset),
    .power             (power),
    .membus_rq_cyc     (rq_cyc),
    .membus_rd_rq      (rd_rq),
    .membus_wr_rq      (wr_rq),
    .membus_wr_rs      (wr_rs),
    .membus_fmc_select (fmc),
    .membus_sel        (sel),
    .membus_ma         (ma),
    .membus_mb_in      (mb_in),
    .membus_addr_ack   (addr_ack_rr),
    .membus_rd_rs      (rd_rs_rr),
    .membus_mb_out     (mb_out_rr),
    .busy              (busy_rr)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rq();
    rq_cyc = '0;
    rd_rq  = '0;
    wr_rq  = '0;
    wr_rs  = '0;
    mb_in  = '0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || busy_rr) && k < 200) begin
      tick();
      k++;
    end
    check("idle", 64'(busy | busy_rr), 64'd0);
  endtask

  // One full cycle on port p; wat = clocks after
  // addr_ack at which wr_rs is driven (-1: never).
  task automatic run_cycle(
    input  int           p,
    input  bit           rd,
    input  bit           wr,
    input  logic [AW-1:0] a,
    input  logic [35:0]  wd,
    input  int           wat,
    output int           ack_t,
    output int           rs_t,
    output logic [35:0]  rdat,
    output int           stray,
    output int           len
  );
    ack_t = -1;
    rs_t  = -1;
    rdat  = '0;
    stray = 0;
    len   = -1;
    rq_cyc[p] = 1'b1;
    rd_rq[p]  = rd;
    wr_rq[p]  = wr;
    ma[p*AW +: AW] = a;
    for (int t = 1; t <= 300; t++) begin
      tick();
      if (addr_ack[p] && ack_t < 0) begin
        ack_t = t;
        rq_cyc[p] = 1'b0;
        rd_rq[p]  = 1'b0;
        wr_rq[p]  = 1'b0;
      end
      if (rd_rs[p]) begin
        rs_t = t;
        rdat = mb_out;
      end else if (mb_out != '0) begin
        stray++;
      end
      if (wat >= 0 && ack_t >= 0 && t == ack_t + wat) begin
        wr_rs[p] = 1'b1;
        mb_in    = wd;
      end else begin
        wr_rs[p] = 1'b0;
        mb_in    = '0;
      end
      if (ack_t >= 0 && t > ack_t && !busy) begin
        len = t;
        break;
      end
    end
    clear_rq();
  endtask

  localparam logic [35:0] W20 = 36'o102030405060;

  int          ack_t, rs_t, stray, len, t2;
  logic [35:0] rdat;
  logic [NP-1:0] rr_seq [3];
  logic [NP-1:0] fx_seq [3];
  int          nr, nf;
  logic        seen_ack, seen_busy;

  initial begin
    reset = 1'b0;
    power = 1'b1;
    fmc   = '0;
    sel   = '0;
    ma    = '0;
    clear_rq();
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(addr_ack), 64'd0);
    check("rst_rdrs", 64'(rd_rs), 64'd0);
    check("rst_mb", 64'(mb_out), 64'd0);
    reset = 1'b1;
    tick();

    // plain write then read of address 20
    run_cycle(0, 0, 1, 15'd20, W20, 2,
              ack_t, rs_t, rdat, stray, len);
    check("wr_ack_t", 64'(ack_t), 64'd1);
    check("wr_len", 64'(len), 64'd7);
    run_cycle(0, 1, 0, 15'd20, '0, -1,
              ack_t, rs_t, rdat, stray, len);
    check("rd_rs_t", 64'(rs_t - ack_t), 64'd3);
    check("rd_data", 64'(rdat), 64'(W20));
    check("rd_stray", 64'(stray), 64'd0);
    check("rd_period", 64'(len), 64'd7);

    // read-pause-write on address 5
    run_cycle(0, 0, 1, 15'd5, 36'o1, 2,
              ack_t, rs_t, rdat, stray, len);
    run_cycle(0, 1, 1, 15'd5, 36'o777, 5,
              ack_t, rs_t, rdat, stray, len);
    check("rpw_data", 64'(rdat), 64'o1);
    check("rpw_rs_t", 64'(rs_t), 64'd4);
    check("rpw_len", 64'(len), 64'd10);
    run_cycle(0, 1, 0, 15'd5, '0, -1,
              ack_t, rs_t, rdat, stray, len);
    check("rpw_new", 64'(rdat), 64'o777);

    // abandoned read-pause-write restores the word
    run_cycle(0, 1, 1, 15'd20, '0, -1,
              ack_t, rs_t, rdat, stray, len);
    check("tmo_rd", 64'(rdat), 64'(W20));
    check("tmo_len", 64'(len), 64'd71);
    run_cycle(0, 1, 0, 15'd20, '0, -1,
              ack_t, rs_t, rdat, stray, len);
    check("restore", 64'(rdat), 64'(W20));

    // abandoned write-only cycle clears the word
    run_cycle(0, 0, 1, 15'd5, '0, -1,
              ack_t, rs_t, rdat, stray, len);
    check("wo_len", 64'(len), 64'd68);
    run_cycle(0, 1, 0, 15'd5, '0, -1,
              ack_t, rs_t, rdat, stray, len);
    check("wo_clear", 64'(rdat), 64'd0);

    // fixed priority: ports 0 and 2 together
    rq_cyc = 4'b0101;
    rd_rq  = 4'b0101;
    ma[0*AW +: AW] = 15'd20;
    ma[2*AW +: AW] = 15'd5;
    tick();
    check("fx_first", 64'(addr_ack), 64'b0001);
    rq_cyc[0] = 1'b0;
    rd_rq[0]  = 1'b0;
    t2 = -1;
    for (int t = 2; t <= 30; t++) begin
      tick();
      if (addr_ack != '0) begin
        t2 = t;
        break;
      end
    end
    check("fx_second", 64'(addr_ack), 64'b0100);
    check("fx_when", 64'(t2), 64'd8);
    clear_rq();
    wait_idle();

    // three rounds of continuous requests
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rq_cyc = 4'b0101;
    rd_rq  = 4'b0101;
    nr = 0;
    nf = 0;
    for (int i = 0; i < 3; i++) begin
      rr_seq[i] = '0;
      fx_seq[i] = '0;
    end
    for (int t = 0; t < 40 && (nr < 3 || nf < 3); t++) begin
      tick();
      if (addr_ack_rr != '0 && nr < 3) begin
        rr_seq[nr] = addr_ack_rr;
        nr++;
      end
      if (addr_ack != '0 && nf < 3) begin
        fx_seq[nf] = addr_ack;
        nf++;
      end
    end
    clear_rq();
    check("rr_g0", 64'(rr_seq[0]), 64'b0001);
    check("rr_g1", 64'(rr_seq[1]), 64'b0100);
    check("rr_g2", 64'(rr_seq[2]), 64'b0001);
    check("fx_g2", 64'(fx_seq[2]), 64'b0001);
    wait_idle();

    // foreign select and fast-memory ports are ignored
    seen_ack  = 1'b0;
    seen_busy = 1'b0;
    sel[1*4 +: 4] = 4'h3;
    rq_cyc[1] = 1'b1;
    rd_rq[1]  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      seen_ack  |= (addr_ack != '0);
      seen_busy |= busy;
    end
    check("sel_ack", 64'(seen_ack), 64'd0);
    check("sel_busy", 64'(seen_busy), 64'd0);
    clear_rq();
    sel = '0;
    seen_ack  = 1'b0;
    seen_busy = 1'b0;
    fmc[3]    = 1'b1;
    rq_cyc[3] = 1'b1;
    wr_rq[3]  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      seen_ack  |= (addr_ack != '0);
      seen_busy |= busy;
    end
    check("fmc_ack", 64'(seen_ack), 64'd0);
    check("fmc_busy", 64'(seen_busy), 64'd0);
    clear_rq();
    fmc = '0;

    // reset in the middle of a read
    rq_cyc[0] = 1'b1;
    rd_rq[0]  = 1'b1;
    ma[0*AW +: AW] = 15'd20;
    tick();
    clear_rq();
    tick();
    check("rd_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();
    check("rstrd_out",
          64'({busy, addr_ack, rd_rs, mb_out}), 64'd0);
    reset = 1'b1;
    tick();

    // power loss while waiting for write data
    rq_cyc[0] = 1'b1;
    wr_rq[0]  = 1'b1;
    ma[0*AW +: AW] = 15'd20;
    tick();
    clear_rq();
    tick();
    power    = 1'b0;
    wr_rs[0] = 1'b1;
    mb_in    = 36'o555;
    tick();
    check("pwr_out",
          64'({busy, addr_ack, rd_rs, mb_out}), 64'd0);
    power = 1'b1;
    clear_rq();
    tick();
    run_cycle(0, 1, 0, 15'd20, '0, -1,
              ack_t, rs_t, rdat, stray, len);
    check("keep20", 64'(rdat), 64'(W20));
    run_cycle(0, 1, 0, 15'd5, '0, -1,
              ack_t, rs_t, rdat, stray, len);
    check("keep5", 64'(rdat), 64'd0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
